riscv_soft_imm_encoder: RTL and testbench

RISCV_SOFT_IMM_ENCODER -- requirements
Module: riscv_soft_imm_encoder

---
 rtl/riscv_soft_imm_encoder.sv | 141 ++++++++++++++
 tb/tb_riscv_soft_imm_encoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_soft_imm_encoder.sv
// rtl/riscv_soft_imm_encoder.sv - two-stage RISC-V immediate encoder; optional range check via RISCV_SOFT_IMM_RANGE_CHECK_EN
module riscv_soft_imm_encoder #(
    parameter int XPR_LEN = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_imm_sel,
    input  logic [XPR_LEN-1:0] in_imm,
    input  logic [31:0]        in_base,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic               out_err,
    input  logic               err_clr,
    output logic [15:0]        err_count
);

    localparam logic [2:0] SEL_I = 3'd0;
    localparam logic [2:0] SEL_S = 3'd1;
    localparam logic [2:0] SEL_B = 3'd2;
    localparam logic [2:0] SEL_U = 3'd3;
    localparam logic [2:0] SEL_J = 3'd4;

    logic               s1_valid;
    logic [2:0]         s1_sel;
    logic [XPR_LEN-1:0] s1_imm;
    logic [31:0]        s1_base;

    logic [31:0] enc_inst;
    logic        enc_err;
    logic        out_advance;
    logic        in_fire;
    logic        out_fire;

    // Output register can take new data whenever it is empty or being drained.
    assign out_advance = !out_valid || out_ready;
    assign in_ready    = !s1_valid || !out_valid || out_ready;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;

`ifdef RISCV_SOFT_IMM_RANGE_CHECK_EN
    logic [XPR_LEN-1:11] hi11;
    logic [XPR_LEN-1:12] hi12;
    logic [XPR_LEN-1:20] hi20;
    logic                fit11;
    logic                fit12;
    logic                fit20;

    // A value fits when every bit above the field's sign bit repeats that sign.
    assign hi11  = s1_imm[XPR_LEN-1:11];
    assign hi12  = s1_imm[XPR_LEN-1:12];
    assign hi20  = s1_imm[XPR_LEN-1:20];
    assign fit11 = (&hi11) || !(|hi11);
    assign fit12 = (&hi12) || !(|hi12);
    assign fit20 = (&hi20) || !(|hi20);
`endif

    always_comb begin
        enc_inst = s1_base;
        enc_err  = 1'b0;
        case (s1_sel)
            SEL_I: begin
                enc_inst = {s1_imm[11:0], s1_base[19:0]};
`ifdef RISCV_SOFT_IMM_RANGE_CHECK_EN
                enc_err  = !fit11;
`endif
            end
            SEL_S: begin
                enc_inst = {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]};
`ifdef RISCV_SOFT_IMM_RANGE_CHECK_EN
                enc_err  = !fit11;
`endif
            end
            SEL_B: begin
                enc_inst = {s1_imm[12], s1_imm[10:5], s1_base[24:12],
                            s1_imm[4:1], s1_imm[11], s1_base[6:0]};
`ifdef RISCV_SOFT_IMM_RANGE_CHECK_EN
                enc_err  = !fit12 || s1_imm[0];
`endif
            end
            SEL_U: begin
                enc_inst = {s1_imm[31:12], s1_base[11:0]};
`ifdef RISCV_SOFT_IMM_RANGE_CHECK_EN
                enc_err  = |s1_imm[11:0];
`endif
            end
            SEL_J: begin
                enc_inst = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                            s1_imm[19:12], s1_base[11:0]};
`ifdef RISCV_SOFT_IMM_RANGE_CHECK_EN
                enc_err  = !fit20 || s1_imm[0];
`endif
            end
            default: begin
                enc_inst = s1_base;
                enc_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_sel    <= 3'd0;
            s1_imm    <= '0;
            s1_base   <= 32'd0;
            out_valid <= 1'b0;
            out_inst  <= 32'd0;
            out_err   <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_sel   <= in_imm_sel;
                s1_imm   <= in_imm;
                s1_base  <= in_base;
            end else if (out_advance) begin
                s1_valid <= 1'b0;
            end
            if (out_advance) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_inst <= enc_inst;
                    out_err  <= enc_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= 16'd0;
        end else if (err_clr) begin
            err_count <= 16'd0;
        end else if (out_fire && out_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_riscv_soft_imm_encoder.sv
// tb/tb_riscv_soft_imm_encoder.sv - directed self-checking bench for riscv_soft_imm_encoder
module tb_riscv_soft_imm_encoder;

`ifdef RISCV_SOFT_IMM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_imm_sel;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic        err_clr;
    logic [15:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_soft_imm_encoder #(.XPR_LEN(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_imm_sel (in_imm_sel),
        .in_imm     (in_imm),
        .in_base    (in_base),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_err    (out_err),
        .err_clr    (err_clr),
        .err_count  (err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        in_imm_sel = 3'd0; in_imm = 32'd0; in_base = 32'd0;
        repeat (2) tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_inst !== 32'd0) begin n_fail++; $display("FAIL reset_out_inst got %h want 0", out_inst); end
        n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got %b want 0", out_err); end
        n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        reset_n = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_formats();
        logic [2:0]  sel_v [7];
        logic [31:0] imm_v [7];
        logic [31:0] base_v [7];
        logic [31:0] inst_v [7];
        logic        err_v [7];
        int          exp_cnt;
        sel_v  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        imm_v  = '{32'hFFFFF800, 32'hFFFFFFFF, 32'h00000FFE, 32'h12345000,
                   32'h000FFFFE, 32'h00000123, 32'h00000800};
        base_v = '{32'h00000013, 32'h00000023, 32'h00000063, 32'h00000037,
                   32'h0000006F, 32'hDEADBEEF, 32'h00000013};
        inst_v = '{32'h80000013, 32'hFE000FA3, 32'h7E000FE3, 32'h12345037,
                   32'h7FFFF06F, 32'hDEADBEEF, 32'h80000013};
        err_v  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RC};
        exp_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_imm_sel = sel_v[i]; in_imm = imm_v[i]; in_base = base_v[i];
            tick();
            in_valid = 1'b0;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fmt%0d_early_valid got %b want 0", i, out_valid); end
            tick();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fmt%0d_latency got %b want 1", i, out_valid); end
            n_checks++; if (out_inst !== inst_v[i]) begin n_fail++; $display("FAIL fmt%0d_inst got %h want %h", i, out_inst, inst_v[i]); end
            n_checks++; if (out_err !== err_v[i]) begin n_fail++; $display("FAIL fmt%0d_err got %b want %b", i, out_err, err_v[i]); end
            exp_cnt += int'(err_v[i]);
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fmt%0d_drain got %b want 0", i, out_valid); end
        end
        n_checks++; if (err_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL fmt_err_count got %0d want %0d", err_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [3];
        logic [31:0] held;
        int acc, got, last_got;
        acc = 0; got = 0; last_got = -10; held = 32'd0;
        for (int i = 0; i < 3; i++) exp_q[i] = (32'(i + 1) << 20) | 32'h13;
        in_imm_sel = 3'd0; in_base = 32'h13;
        for (int c = 0; c < 14; c++) begin
            out_ready = (c >= 5);
            in_valid = (acc < 3);
            in_imm = 32'(acc + 1);
            #1;
            if (c == 2) held = out_inst;
            if (c == 4) begin
                n_checks++; if (acc !== 2) begin n_fail++; $display("FAIL stall_accepted got %0d want 2", acc); end
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid got %b want 1", out_valid); end
                n_checks++; if (out_inst !== held || out_inst !== exp_q[0]) begin n_fail++; $display("FAIL stall_hold got %h want %h", out_inst, exp_q[0]); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (got >= 3) begin
                    n_fail++; $display("FAIL b2b_extra got %h want none", out_inst);
                end else if (out_inst !== exp_q[got]) begin
                    n_fail++; $display("FAIL b2b_order%0d got %h want %h", got, out_inst, exp_q[got]);
                end
                if (got > 0) begin
                    n_checks++; if (c !== last_got + 1) begin n_fail++; $display("FAIL b2b_gap got cycle %0d want %0d", c, last_got + 1); end
                end
                last_got = c;
                got++;
            end
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (got !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", got); end
    endtask

    task automatic test_reset_flush();
        int seen;
        seen = 0;
        out_ready = 1'b1; in_imm_sel = 3'd5; in_base = 32'hA5A5A5A5; in_imm = 32'd0;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid got %b want 1", out_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL flush_err_count got %0d want 0", err_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen++;
            tick();
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_ghost got %0d outputs want 0", seen); end
        n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL flush_err_after got %0d want 0", err_count); end
    endtask

    task automatic test_err_clr();
        out_ready = 1'b1; in_imm_sel = 3'd7; in_base = 32'h00000013; in_imm = 32'd0;
        in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
        n_checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin n_fail++; $display("FAIL clr_first_out got v%b e%b want v1 e1", out_valid, out_err); end
        tick();
        n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL clr_incr got %0d want 1", err_count); end
        in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_second_valid got %b want 1", out_valid); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL clr_wins got %0d want 0", err_count); end
        in_valid = 1'b1; tick(); in_valid = 1'b0; tick(); tick();
        n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL clr_recount got %0d want 1", err_count); end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_reset_flush();
        test_err_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
